// File: rtl/jpeg_output_cx_buf_if.sv
// Handshake/bus bundle for the chroma output buffer.
// master = producer/consumer side (IDCT writer + colour-convert reader),
// slave  = the buffer itself.
interface jpeg_output_cx_buf_if #(
  parameter int DATA_W = 32
);
  logic              flush_i;
  logic [1:0]        mode_i;
  logic              push_i;
  logic [5:0]        wr_idx_i;
  logic [DATA_W-1:0] data_in_i;
  logic              wr_last_i;
  logic              wr_ready_o;
  logic [DATA_W-1:0] data_out_o;
  logic              valid_o;
  logic              pop_i;
  logic [31:0]       level_o;
  logic              idle_o;

  modport master (
    output flush_i, mode_i, push_i, wr_idx_i, data_in_i, wr_last_i, pop_i,
    input  wr_ready_o, data_out_o, valid_o, level_o, idle_o
  );

  modport slave (
    input  flush_i, mode_i, push_i, wr_idx_i, data_in_i, wr_last_i, pop_i,
    output wr_ready_o, data_out_o, valid_o, level_o, idle_o
  );
endinterface

// File: rtl/jpeg_output_cx_buf.sv
// Chroma output buffer: SLOTS ring of 8x8 blocks, each replayed in raster
// order with per-block 4:4:4 / 4:2:2 / 4:2:0 upsampling into a 2-entry
// skid buffer. The read side issues at most one RAM read per cycle.
module jpeg_output_cx_buf #(
  parameter int DATA_W = 32,
  parameter int SLOTS  = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  jpeg_output_cx_buf_if.slave  bus
);
  localparam int SW    = $clog2(SLOTS);
  localparam int AW    = SW + 6;
  localparam int DEPTH = 64 * SLOTS;
  localparam logic [SW:0] FULL_CNT = (SW + 1)'(SLOTS);

  // Number of output samples a block expands to in the given mode.
  function automatic logic [8:0] expand_len(input logic [1:0] m);
    case (m)
      2'd1:    return 9'd128;
      2'd2:    return 9'd256;
      default: return 9'd64;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [1:0]        slot_mode [0:SLOTS-1];

  logic [SW-1:0]     wr_slot;
  logic [SW-1:0]     rd_slot;
  logic [SW:0]       used_q;
  logic [7:0]        k;
  logic [DATA_W-1:0] rd_data;
  logic              inflight;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic [31:0]       level;

  logic              clear;
  logic              ready;
  logic              accept;
  logic              commit;
  logic              pop_fire;
  logic              issue;
  logic              last;
  logic              release_s;
  logic [1:0]        rd_mode;
  logic [2:0]        src_row;
  logic [2:0]        src_col;
  logic [AW-1:0]     rd_addr;
  logic [8:0]        e_len;

  assign clear    = rst_i || bus.flush_i;
  assign ready    = (used_q != FULL_CNT);
  assign accept   = bus.push_i && ready && !clear;
  assign commit   = accept && bus.wr_last_i;
  assign pop_fire = (cnt != 2'd0) && bus.pop_i;

  // Source address of output sample k for the slot being read, plus issue control.
  always_comb begin
    rd_mode = slot_mode[rd_slot];
    src_row = k[5:3];
    src_col = k[2:0];
    case (rd_mode)
      2'd1: begin
        src_row = k[5:3];
        src_col = {k[6], k[2:1]};
      end
      2'd2: begin
        src_row = {k[7], k[5:4]};
        src_col = {k[6], k[2:1]};
      end
      default: begin
        src_row = k[5:3];
        src_col = k[2:0];
      end
    endcase
    rd_addr   = {rd_slot, src_row, src_col};
    e_len     = expand_len(rd_mode);
    last      = ({1'b0, k} == (e_len - 9'd1));
    // Occupancy after this cycle's pop must leave room for one more sample.
    issue     = (used_q != '0) && !clear &&
                (({1'b0, cnt} + {2'b00, inflight} - {2'b00, pop_fire}) < 3'd2);
    release_s = issue && last;
  end

  // Sample RAM, per-slot mode latch and the 1-cycle registered RAM read.
  always_ff @(posedge clk_i) begin
    if (accept) mem[{wr_slot, bus.wr_idx_i}] <= bus.data_in_i;
    if (commit) slot_mode[wr_slot] <= bus.mode_i;
    if (issue)  rd_data <= mem[rd_addr];
  end

  // Slot ring, output counter, skid buffer and level bookkeeping.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_slot  <= '0;
      rd_slot  <= '0;
      used_q   <= '0;
      k        <= 8'd0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
      level    <= 32'd0;
    end else begin
      if (commit)    wr_slot <= wr_slot + SW'(1);
      if (release_s) rd_slot <= rd_slot + SW'(1);
      if (commit && !release_s)      used_q <= used_q + (SW + 1)'(1);
      else if (release_s && !commit) used_q <= used_q - (SW + 1)'(1);
      if (issue) k <= release_s ? 8'd0 : (k + 8'd1);
      inflight <= issue;
      level <= level + {23'd0, (commit ? expand_len(bus.mode_i) : 9'd0)}
                     - {31'd0, pop_fire};
      case ({inflight, pop_fire})
        2'b11: begin
          if (cnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= rd_data;
          end else begin
            buf0 <= rd_data;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) buf0 <= rd_data;
          else             buf1 <= rd_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ready_o = ready;
  assign bus.data_out_o = buf0;
  assign bus.valid_o    = (cnt != 2'd0);
  assign bus.level_o    = level;
  assign bus.idle_o     = (used_q == '0) && (cnt == 2'd0) && !inflight;
endmodule

// File: doc/jpeg_output_cx_buf.md
# jpeg_output_cx_buf

Parametrised chroma output buffer for the JPEG decoder back end. It stores SLOTS complete 8x8 chroma blocks from the IDCT and replays each one in raster order for the colour-convert stage. Per block it upsamples for 4:4:4, 4:2:2 or 4:2:0. The subsampling mode is latched per block, so the mode can change between blocks without a flush.

## Interface
Parameters:
- DATA_W, 32: sample word width.
- SLOTS, 4: number of 64-entry block slots. Power of two, at least 2. RAM depth is 64*SLOTS.

Ports:
- clk_i, in, 1: single clock. All state updates on the rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- flush_i, in, 1: synchronous clear of all state, same effect as rst_i. RAM contents are not cleared.
- mode_i, in, 2: 0 = 4:4:4, 1 = 4:2:2, 2 = 4:2:0, 3 = treated as 4:4:4. Sampled only on the commit cycle.
- push_i, in, 1: write strobe. Accepted only when wr_ready_o = 1.
- wr_idx_i, in, 6: raster index (row*8+col) of the sample in the current write slot. Any write order is allowed.
- data_in_i, in, DATA_W: write data.
- wr_last_i, in, 1: qualifies push_i; marks the final write of the block and commits the slot.
- wr_ready_o, out, 1: a free slot exists.
- data_out_o, out, DATA_W: output sample.
- valid_o, out, 1: data_out_o is valid.
- pop_i, in, 1: consumer accepts the sample when valid_o && pop_i.
- level_o, out, 32: output samples committed but not yet popped.
- idle_o, out, 1: no committed blocks and no output pending.

## Operation
- Slot ring:
  - wr_slot and rd_slot pointers, each clog2(SLOTS) bits, wrap modulo SLOTS.
  - used_q counts committed slots, 0..SLOTS.
  - wr_ready_o = (used_q != SLOTS).
- Write path:
  - An accepted push writes RAM address {wr_slot, wr_idx_i}.
  - An accepted push with wr_last_i stores mode_i into slot_mode[wr_slot], advances wr_slot and increments used_q.
  - A push while wr_ready_o = 0 is dropped with no state change.
- Expansion per block (E = output samples, k = output counter 0..E-1, r = k[5:3], c = k[2:0]):
  - 4:4:4: E = 64. Source address = k[5:0].
  - 4:2:2: E = 128. Half h = k[6]. Source row = r, source column = h*4 + (c>>1).
  - 4:2:0: E = 256. Quadrant q = k[7:6], output in order TL, TR, BL, BR. Source row = q[1]*4 + (r>>1), source column = q[0]*4 + (c>>1).
  - RAM read address = {rd_slot, src_row, src_col}.
- Read issue:
  - A read issues when used_q > 0 and the 2-entry output buffer will have room.
  - Each issued read increments k.
  - When the read for k = E-1 issues: k clears, rd_slot advances, used_q decrements. That slot may be written from the next cycle.
  - If commit and release fall in the same cycle, used_q is unchanged.
- Output:
  - The RAM has 1-cycle read latency and feeds a 2-entry skid buffer.
  - valid_o is high whenever the buffer is non-empty.
  - data_out_o is held stable while valid_o && !pop_i.
- Level:
  - On commit, level_o increases by E of the committed mode.
  - On each pop (valid_o && pop_i), level_o decreases by 1.
  - Both in one cycle: net change E-1.
- idle_o = (used_q == 0) && !valid_o && no read in flight.

## Timing
- Reset/flush values:
  - wr_ready_o = 1, valid_o = 0, level_o = 0, idle_o = 1, data_out_o = 0.
  - All pointers, k and used_q = 0.
  - flush_i has priority over push_i and pop_i in the same cycle.
- Latency: the first output is valid 2 cycles after the commit edge, i.e. the commit at edge N gives valid_o = 1 after edge N+2.
- Throughput:
  - 1 sample/cycle with pop_i held high. There are no bubbles across block boundaries when the next slot is committed.
  - After a stall, full rate resumes on the first pop cycle.
- Write of the currently-reading slot is impossible; the full check guarantees it.
- A rst_i or flush_i mid-block discards any partial write and all pending output. The next accepted write goes to slot 0.

## Test plan
- 4:4:4 pass-through: write block 0 with data = idx in reverse order, wr_last_i on idx 0, pop_i = 1 -> 64 outputs 0,1,...,63. level_o goes 64 -> 0. Commit-to-valid is 2 cycles.
- 4:2:0: write a block with data = idx -> outputs 0,0,1,1,2,2,3,3, rows repeated. Output 64 = 4, output 128 = 32, output 192 = 36, output 255 = 63. level_o starts at 256.
- 4:2:2 followed by 4:4:4 without flush: 128 outputs, first row 0,0,1,1,2,2,3,3, output 64 = 4. Then 64 outputs of the second block with no gap.
- Full/backpressure: SLOTS = 4, pop_i = 0, commit 4 blocks -> wr_ready_o = 0 and a 5th push is dropped. Then pop_i = 1 releases a slot and wr_ready_o rises. No data is lost or duplicated.
- Random pop_i stalls (about 50%) over 8 mixed-mode blocks: data_out_o stays stable while stalled, the output sequence matches the scoreboard, and level_o is exact every cycle.
- flush_i asserted mid-readout of a 4:2:0 block -> the next cycle has valid_o = 0, level_o = 0, wr_ready_o = 1, idle_o = 1. A fresh block then reads out correctly from slot 0.
